// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle for the hazard controller.
// Purpose: groups the ID/EX and IF/ID status taps and the stall/flush controls so the
//          pipeline and the hazard controller share one connection.
// Signals:
//   ifid_inst_i      instruction in ID (from IF/ID)
//   idex_inst_i      instruction in EX (ID/EX inst_o)
//   idex_MemToReg_i  EX instruction is a load
//   idex_RegWrite_i  EX instruction writes a register
//   branch_taken_i   branch resolved taken in ID
//   jump_i           jump decoded in ID
//   dmem_busy_i      data memory not ready
//   pc_write_o       PC update enable
//   ifid_write_o     IF/ID load enable
//   ifid_flush_o     IF/ID clear
//   idex_bubble_o    zero ID/EX control inputs
//   pipe_hold_o      hold ID/EX, EX/MEM, MEM/WB
//   stall_cnt_o      cycles with pc_write_o=0
//   flush_cnt_o      cycles with ifid_flush_o=1
// Modports: master = pipeline side, slave = hazard controller side.
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [31:0]      ifid_inst_i;
    logic [31:0]      idex_inst_i;
    logic             idex_MemToReg_i;
    logic             idex_RegWrite_i;
    logic             branch_taken_i;
    logic             jump_i;
    logic             dmem_busy_i;
    logic             pc_write_o;
    logic             ifid_write_o;
    logic             ifid_flush_o;
    logic             idex_bubble_o;
    logic             pipe_hold_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    modport master (
        output ifid_inst_i, idex_inst_i, idex_MemToReg_i, idex_RegWrite_i,
               branch_taken_i, jump_i, dmem_busy_i,
        input  pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_hold_o,
               stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  ifid_inst_i, idex_inst_i, idex_MemToReg_i, idex_RegWrite_i,
               branch_taken_i, jump_i, dmem_busy_i,
        output pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_hold_o,
               stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller (control-side companion of the ID/EX register).
// Purpose: detects load-use hazards and inserts LOAD_STALL_CYCLES bubbles, flushes IF/ID on a
//          taken branch or jump, freezes the pipe while data memory is busy, and counts stall
//          and flush cycles with saturating counters.
// Ports:
//   clk_i  clock, rising edge
//   rst_i  synchronous reset, active-low
//   bus    hazard_ctrl_if.slave: pipeline status in, stall/flush controls and counters out
// Control outputs are combinational; counters update on the edge after the qualifying cycle.
module hazard_ctrl #(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned CNT_W             = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    hazard_ctrl_if.slave bus
);

    typedef enum logic [0:0] {StRun, StLdStall} state_e;

    // Bubbles remaining after the first one, which is issued from StRun.
    localparam logic [1:0] StallInit = 2'(LOAD_STALL_CYCLES - 1);

    state_e           state_q, state_d;
    logic [1:0]       stall_left_q, stall_left_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    logic [5:0] ifid_op;
    logic [4:0] ifid_rs, ifid_rt, idex_rt;
    logic       ifid_uses_rt;
    logic       load_use;

    logic pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold;

    assign ifid_op = bus.ifid_inst_i[31:26];
    assign ifid_rs = bus.ifid_inst_i[25:21];
    assign ifid_rt = bus.ifid_inst_i[20:16];
    assign idex_rt = bus.idex_inst_i[20:16];

    // R-type, sw and beq read rt as a source; everything else (e.g. addi, lw) writes it.
    assign ifid_uses_rt = (ifid_op == 6'b000000) || (ifid_op == 6'b101011) ||
                          (ifid_op == 6'b000100);

    assign load_use = bus.idex_MemToReg_i && bus.idex_RegWrite_i && (idex_rt != 5'd0) &&
                      ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

    always_comb begin
        state_d      = state_q;
        stall_left_d = stall_left_q;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        pipe_hold    = 1'b0;

        if (!rst_i) begin
            // Outputs stay at defaults; the register block performs the reset.
        end else if (bus.dmem_busy_i) begin
            // Whole pipe frozen; FSM state is held as well.
            pipe_hold  = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (state_q == StLdStall) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_bubble  = 1'b1;
            stall_left_d = stall_left_q - 2'd1;
            if (stall_left_q <= 2'd1) begin
                state_d = StRun;
            end
        end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
                state_d      = StLdStall;
                stall_left_d = StallInit;
            end
        end else if (bus.branch_taken_i || bus.jump_i) begin
            ifid_flush = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= StRun;
            stall_left_q <= 2'd0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            stall_left_q <= stall_left_d;
            if (!pc_write && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (ifid_flush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign bus.pc_write_o    = pc_write;
    assign bus.ifid_write_o  = ifid_write;
    assign bus.ifid_flush_o  = ifid_flush;
    assign bus.idex_bubble_o = idex_bubble;
    assign bus.pipe_hold_o   = pipe_hold;
    assign bus.stall_cnt_o   = stall_cnt_q;
    assign bus.flush_cnt_o   = flush_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller; the control-side counterpart of the ID/EX pipeline register.
- Consumes the ID/EX register's outputs (inst, MemToReg, RegWrite) and the IF/ID instruction.
- Drives back into the pipeline: PC write-enable, IF/ID write-enable and flush, ID/EX bubble (zero control bits), and a global hold for data-memory wait.
- Implements a multi-cycle load-use stall FSM, branch/jump flush, memory-wait freeze, and saturating stall/flush event counters.

Parameters:
LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..3; use 2 when forwarding is absent)
CNT_W, 16, width of the stall and flush event counters

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-low
ifid_inst_i  in  32  instruction currently in ID (from IF/ID)
idex_inst_i  in  32  instruction currently in EX (ID/EX inst_o)
idex_MemToReg_i  in  1  ID/EX MemToReg_o: instruction in EX is a load
idex_RegWrite_i  in  1  ID/EX RegWrite_o
branch_taken_i  in  1  branch resolved taken in ID
jump_i  in  1  jump decoded in ID
dmem_busy_i  in  1  data memory not ready; whole pipe must freeze
pc_write_o  out  1  PC update enable
ifid_write_o  out  1  IF/ID load enable
ifid_flush_o  out  1  IF/ID clear (insert NOP)
idex_bubble_o  out  1  zero all control inputs of ID/EX this cycle
pipe_hold_o  out  1  hold ID/EX, EX/MEM and MEM/WB (no update)
stall_cnt_o  out  CNT_W  cycles with pc_write_o=0
flush_cnt_o  out  CNT_W  cycles with ifid_flush_o=1

Behaviour:
- Field extraction:
  - rs = inst[25:21], rt = inst[20:16], opcode = inst[31:26].
  - ID instruction "uses rt" iff opcode is 000000 (R-type), 101011 (sw) or 000100 (beq).
- load_use (combinational): idex_MemToReg_i & idex_RegWrite_i & (idex rt != 0) & (idex rt == ifid rs, or ifid uses rt & idex rt == ifid rt).
- FSM states: RUN, LD_STALL. Down-counter stall_left, 2 bits.
- Output priority each cycle: reset > dmem_busy_i > LD_STALL / load_use > branch/jump flush > default.
- Reset (rst_i=0 at an edge):
  - State goes to RUN; stall_left=0; both counters 0.
  - While rst_i=0, outputs are forced to defaults.
- Defaults: pc_write_o=1, ifid_write_o=1, ifid_flush_o=0, idex_bubble_o=0, pipe_hold_o=0.
- dmem_busy_i=1, any state:
  - pipe_hold_o=1, pc_write_o=0, ifid_write_o=0, ifid_flush_o=0, idex_bubble_o=0.
  - State and stall_left frozen; branch/jump ignored.
- RUN with load_use=1:
  - Same cycle: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1.
  - If LOAD_STALL_CYCLES>1: next state LD_STALL with stall_left=LOAD_STALL_CYCLES-1. Otherwise stay RUN.
- LD_STALL:
  - Outputs pc_write_o=0, ifid_write_o=0, idex_bubble_o=1 regardless of load_use.
  - stall_left decrements each non-held cycle; at the edge where stall_left==1, state goes to RUN.
- RUN, no load_use, branch_taken_i|jump_i:
  - ifid_flush_o=1 for that cycle; pc_write_o=1.
  - Branch/jump arriving during a stall is ignored and re-evaluated once ID advances.
- Latency:
  - Control outputs are combinational from state and inputs (zero latency).
  - Counters update at the clock edge following the qualifying cycle.
- Counters:
  - stall_cnt_o increments on every cycle with pc_write_o=0 and rst_i=1; this includes memory-wait cycles.
  - flush_cnt_o increments on every cycle with ifid_flush_o=1.
  - Both saturate at 2^CNT_W-1 (no wrap).
- Reset asserted mid-stall: the FSM abandons LD_STALL; the next cycle after release runs normally in RUN.

Test Plan:
- lw $t0 in EX (idex_inst rt=8, MemToReg=1, RegWrite=1), ID add rs=8 -> 1 cycle: pc_write=0, ifid_write=0, idex_bubble=1; then defaults; stall_cnt=1.
- Same as above with LOAD_STALL_CYCLES=2 -> exactly 2 bubble cycles, then RUN; stall_cnt=2.
- Load rt=0, ID rs=0 -> no stall. Load rt=9, ID addi (opcode 001000) with rt=9 -> no stall, since addi does not use rt.
- branch_taken_i=1 in RUN, no hazard -> ifid_flush=1 for one cycle; flush_cnt=1. Same cycle with load_use=1 -> stall only, no flush, flush_cnt=0.
- dmem_busy_i high 3 cycles during LD_STALL (LOAD_STALL_CYCLES=3, stall_left=2) -> pipe_hold=1 for 3 cycles, stall_left stays 2; afterwards 2 more bubbles; stall_cnt=6 total.
- CNT_W=4, 20 stall cycles -> stall_cnt_o holds 15. rst_i=0 one cycle -> counters 0, state RUN, outputs at defaults.
